// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame buffer and the FFT core it feeds:
// default frame geometry, control FSM encoding and the packed complex word.
package fft_pkg;

  localparam int WIDTH = 36;
  localparam int N     = 16;
  localparam int HALF  = WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } fft_state_e;

  // Real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample stream in, frame and start/done pulse pair towards the FFT core.
interface fft_frame_buffer_if #(
  parameter int WIDTH = 36,
  parameter int N     = 16
);

  // sample_valid is a one-cycle strobe with no ready: the buffer never stalls
  // the source and drops a sample when its target bank is full. fft_start and
  // fft_done are single-cycle pulses bracketing one FFT run on frame_out.
  logic signed [WIDTH/2-1:0]  sample_in;
  logic                       sample_valid;
  logic                       fft_done;
  logic [N-1:0][WIDTH-1:0]    frame_out;
  logic                       fft_start;
  logic                       fft_busy;

  modport master (
    output sample_in, sample_valid, fft_done,
    input  frame_out, fft_start, fft_busy
  );

  modport slave (
    input  sample_in, sample_valid, fft_done,
    output frame_out, fft_start, fft_busy
  );

endinterface

// File: rtl/fft_sample_bank.sv
// N-entry register bank: one indexed write port, whole bank visible in parallel.
module fft_sample_bank #(
  parameter int WIDTH = 36,
  parameter int N     = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [N-1:0][WIDTH-1:0] rd_data
);

  logic [N-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: fills one bank with real samples while the FFT core
// reads the other, and hands full banks over with a start/done pulse pair.
module fft_frame_buffer #(
  parameter int WIDTH = 36,
  parameter int N     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_frame_buffer_if.slave    bus,
  output logic                 overflow,
  output logic [7:0]           drop_count,
  output fft_pkg::fft_state_e  fsm_state
);

  import fft_pkg::*;

  localparam int HALF  = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  fft_state_e              state_q, state_d;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_bank, rd_bank;
  logic [1:0]              full, full_d;
  logic                    accept, drop, frame_done, done_ok, launch, launch_bank;
  logic [WIDTH-1:0]        wr_data;
  logic [N-1:0][WIDTH-1:0] bank0_data, bank1_data;

  // The bank under FFT stays full until fft_done, so it can never be targeted.
  assign accept      = bus.sample_valid & ~full[wr_bank];
  assign drop        = bus.sample_valid &  full[wr_bank];
  assign frame_done  = accept && (wr_idx == LAST_IDX);
  assign done_ok     = (state_q == ST_BUSY) && bus.fft_done;
  assign launch      = (state_q == ST_IDLE) && (full != 2'b00);
  // With both full, wr_bank has wrapped back onto the older bank.
  assign launch_bank = (full == 2'b11) ? wr_bank : full[1];
  assign wr_data     = {bus.sample_in, {(WIDTH-HALF){1'b0}}};

  fft_sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept & ~wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_data (bank0_data)
  );

  fft_sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept & wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_data (bank1_data)
  );

  assign bus.frame_out = rd_bank ? bank1_data : bank0_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (full != 2'b00) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (bus.fft_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.fft_start = (state_q == ST_START);
    bus.fft_busy  = (state_q != ST_IDLE);
    fsm_state     = state_q;
  end

  // Clearing the read bank and filling the other can coincide on one edge.
  always_comb begin
    full_d = full;
    if (done_ok)    full_d[rd_bank] = 1'b0;
    if (frame_done) full_d[wr_bank] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      full <= full_d;
      if (accept) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (launch) rd_bank <= launch_bank;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: frame capture, handover timing,
// overflow accounting, done/fill collision and reset during a run.
module tb_fft_frame_buffer;

  import fft_pkg::*;

  localparam int W  = 36;
  localparam int NP = 16;
  localparam int H  = W / 2;

  typedef logic [NP-1:0][W-1:0] frame_t;

  logic        clock;
  logic        reset;
  logic        overflow;
  logic [7:0]  drop_count;
  fft_state_e  fsm_state;

  int total;
  int bad;
  int start_count;
  logic [W-1:0] exp_q[$];

  fft_frame_buffer_if #(.WIDTH(W), .N(NP)) bus ();

  fft_frame_buffer #(.WIDTH(W), .N(NP)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (bus.fft_start === 1'b1) start_count++;
  end

  function automatic logic [W-1:0] cword(input logic signed [H-1:0] v);
    return {v, {H{1'b0}}};
  endfunction

  function automatic frame_t frame_from_q();
    frame_t f;
    f = '0;
    for (int i = 0; i < NP && i < exp_q.size(); i++) f[i] = exp_q[i];
    return f;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.fft_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic send(input logic signed [H-1:0] v);
    bus.sample_in = v;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.fft_done = 1'b1;
    step();
    bus.fft_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
    total++; if (bus.fft_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", bus.fft_start); end
    total++; if (bus.fft_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.fft_busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
    total++; if (bus.frame_out !== frame_t'(0)) begin bad++; $display("FAIL reset_frame: got %h want 0", bus.frame_out); end
  endtask

  task automatic test_single_frame();
    int s0;
    frame_t exp_f;
    do_reset();
    s0 = start_count;
    exp_q.delete();
    for (int v = 1; v <= 16; v++) begin
      send(H'(v));
      exp_q.push_back(cword(H'(v)));
    end
    exp_f = frame_from_q();
    total++; if (bus.fft_start !== 1'b0) begin bad++; $display("FAIL start_early: got %b want 0", bus.fft_start); end
    step();
    total++; if (bus.fft_start !== 1'b1) begin bad++; $display("FAIL start_latency: got %b want 1", bus.fft_start); end
    total++; if (bus.frame_out[0] !== {18'd1, 18'd0}) begin bad++; $display("FAIL frame_first: got %h want %h", bus.frame_out[0], {18'd1, 18'd0}); end
    total++; if (bus.frame_out[15] !== {18'd16, 18'd0}) begin bad++; $display("FAIL frame_last: got %h want %h", bus.frame_out[15], {18'd16, 18'd0}); end
    total++; if (bus.frame_out !== exp_f) begin bad++; $display("FAIL frame_ramp: got %h want %h", bus.frame_out, exp_f); end
    step();
    total++; if ({bus.fft_start, bus.fft_busy} !== 2'b01) begin bad++; $display("FAIL busy_phase: got %b want 01", {bus.fft_start, bus.fft_busy}); end
    repeat (3) step();
    total++; if (start_count - s0 !== 1) begin bad++; $display("FAIL start_once: got %0d want 1", start_count - s0); end
    pulse_done();
    total++; if (bus.fft_busy !== 1'b0) begin bad++; $display("FAIL done_idle: got %b want 0", bus.fft_busy); end
  endtask

  task automatic test_overflow();
    frame_t frame0, frame1;
    int changes;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(cword(H'(100 + i)));
    frame0 = frame_from_q();
    exp_q.delete();
    for (int i = 16; i < 32; i++) exp_q.push_back(cword(H'(100 + i)));
    frame1 = frame_from_q();
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      send(H'(100 + i));
      if (i >= 15 && bus.frame_out !== frame0) changes++;
    end
    total++; if (changes !== 0) begin bad++; $display("FAIL ovf_frame_stable: got %0d changes want 0", changes); end
    total++; if (bus.frame_out !== frame0) begin bad++; $display("FAIL ovf_frame0: got %h want %h", bus.frame_out, frame0); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    total++; if (drop_count !== 8'd8) begin bad++; $display("FAIL ovf_drops: got %0d want 8", drop_count); end
    total++; if (fsm_state !== ST_BUSY) begin bad++; $display("FAIL ovf_state: got %0d want %0d", fsm_state, ST_BUSY); end
    pulse_done();
    step();
    total++; if (bus.fft_start !== 1'b1) begin bad++; $display("FAIL ovf_second_start: got %b want 1", bus.fft_start); end
    total++; if (bus.frame_out !== frame1) begin bad++; $display("FAIL ovf_frame1: got %h want %h", bus.frame_out, frame1); end
  endtask

  task automatic test_two_frames();
    frame_t neg_f, pos_f;
    int s0;
    do_reset();
    s0 = start_count;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(cword(-18'sd5));
    neg_f = frame_from_q();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(cword(18'sd7));
    pos_f = frame_from_q();
    for (int i = 0; i < 16; i++) send(-18'sd5);
    for (int i = 0; i < 16; i++) send(18'sd7);
    total++; if (bus.frame_out !== neg_f) begin bad++; $display("FAIL two_neg_frame: got %h want %h", bus.frame_out, neg_f); end
    pulse_done();
    total++; if ({fsm_state, bus.fft_start} !== {ST_IDLE, 1'b0}) begin bad++; $display("FAIL two_idle: got %0d/%b want %0d/0", fsm_state, bus.fft_start, ST_IDLE); end
    step();
    total++; if ({fsm_state, bus.fft_start} !== {ST_START, 1'b1}) begin bad++; $display("FAIL two_start: got %0d/%b want %0d/1", fsm_state, bus.fft_start, ST_START); end
    total++; if (bus.frame_out !== pos_f) begin bad++; $display("FAIL two_pos_frame: got %h want %h", bus.frame_out, pos_f); end
    step();
    total++; if (start_count - s0 !== 2) begin bad++; $display("FAIL two_starts: got %0d want 2", start_count - s0); end
  endtask

  task automatic test_done_collision();
    frame_t frame1;
    do_reset();
    exp_q.delete();
    for (int v = 1; v <= 16; v++) send(H'(v));
    for (int v = 201; v <= 215; v++) begin
      send(H'(v));
      exp_q.push_back(cword(H'(v)));
    end
    exp_q.push_back(cword(18'sd216));
    frame1 = frame_from_q();
    bus.fft_done = 1'b1;
    send(18'sd216);
    bus.fft_done = 1'b0;
    total++; if ({overflow, drop_count} !== 9'd0) begin bad++; $display("FAIL coll_no_drop: got %b/%0d want 0/0", overflow, drop_count); end
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL coll_idle: got %0d want %0d", fsm_state, ST_IDLE); end
    step();
    total++; if (bus.fft_start !== 1'b1) begin bad++; $display("FAIL coll_start: got %b want 1", bus.fft_start); end
    total++; if (bus.frame_out !== frame1) begin bad++; $display("FAIL coll_frame1: got %h want %h", bus.frame_out, frame1); end
  endtask

  task automatic test_reset_busy();
    int s0;
    frame_t exp_f;
    do_reset();
    for (int v = 1; v <= 16; v++) send(H'(v));
    step();
    step();
    total++; if (fsm_state !== ST_BUSY) begin bad++; $display("FAIL rb_busy: got %0d want %0d", fsm_state, ST_BUSY); end
    for (int v = 30; v < 35; v++) send(H'(v));
    do_reset();
    s0 = start_count;
    pulse_done();
    repeat (3) step();
    total++; if (start_count - s0 !== 0) begin bad++; $display("FAIL rb_no_start: got %0d want 0", start_count - s0); end
    total++; if (bus.fft_busy !== 1'b0) begin bad++; $display("FAIL rb_not_busy: got %b want 0", bus.fft_busy); end
    total++; if (bus.frame_out !== frame_t'(0)) begin bad++; $display("FAIL rb_frame_zero: got %h want 0", bus.frame_out); end
    exp_q.delete();
    for (int v = 50; v <= 65; v++) begin
      send(H'(v));
      exp_q.push_back(cword(H'(v)));
    end
    exp_f = frame_from_q();
    step();
    total++; if (bus.fft_start !== 1'b1) begin bad++; $display("FAIL rb_restart: got %b want 1", bus.fft_start); end
    total++; if (bus.frame_out !== exp_f) begin bad++; $display("FAIL rb_new_frame: got %h want %h", bus.frame_out, exp_f); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      send(H'(i));
      if (i == 286) begin
        total++; if (drop_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", drop_count); end
      end
      if (i == 287) begin
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", drop_count); end
      end
    end
    total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow: got %b want 1", overflow); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    start_count = 0;
    reset = 1'b1;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.fft_done = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_two_frames();
    test_done_collision();
    test_reset_busy();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
